// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: formats store lanes, runs a req/ack bus cycle,
// stalls the pipeline while it is outstanding and extends load data.
// Build option: define LSU_TIMEOUT_EN to abort transactions that wait TIMEOUT_CYCLES without an ack.
module mem_stage_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_addr_m,
  input  logic [31:0]       i_wdata_m,
  input  logic              i_mem_write_m,
  input  logic              i_mem_read_m,
  input  logic [2:0]        i_funct3_m,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [31:0]       o_bus_wdata,
  output logic [3:0]        o_bus_be,
  input  logic              i_bus_ack,
  input  logic [31:0]       i_bus_rdata,
  output logic              o_stall,
  output logic [31:0]       o_rdata_m,
  output logic              o_misaligned,
  output logic              o_bus_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              misaligned_q, misaligned_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        offset_q, offset_d;

  logic              access;
  logic [1:0]        offset;
  logic              is_half;
  logic              is_word;
  logic              misaligned;
  logic [3:0]        be_fmt;
  logic [31:0]       wdata_fmt;
  logic              timeout;
  logic              stall;

  assign access     = i_mem_write_m | i_mem_read_m;
  assign offset     = i_addr_m[1:0];
  assign is_half    = (i_funct3_m[1:0] == 2'b01);
  assign is_word    = i_funct3_m[1];
  assign misaligned = (is_half & offset[0]) | (is_word & (|offset));

  // Selects the addressed byte/half of the bus word and extends it; funct3[2] means unsigned.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [1:0]  off,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3[1:0])
      2'b00:   fmt_load = {{24{b[7] & ~f3[2]}}, b};
      2'b01:   fmt_load = {{16{h[15] & ~f3[2]}}, h};
      default: fmt_load = word;
    endcase
  endfunction

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    be_fmt    = 4'b1111;
    wdata_fmt = i_wdata_m;
    case (i_funct3_m[1:0])
      2'b00: begin
        wdata_fmt = {4{i_wdata_m[7:0]}};
        if (i_mem_write_m) be_fmt = 4'b0001 << offset;
      end
      2'b01: begin
        wdata_fmt = {2{i_wdata_m[15:0]}};
        if (i_mem_write_m) be_fmt = offset[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             err_q;

  // Counter is held at zero outside REQ, so every REQ entry starts a fresh wait.
  always_ff @(posedge i_clk) begin
    if (i_rst || (state_q != REQ)) wait_cnt_q <= '0;
    else                           wait_cnt_q <= wait_cnt_q + 1'b1;
  end

  assign timeout = (state_q == REQ) && !i_bus_ack &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= timeout;
  end

  assign o_bus_err = err_q;
`else
  assign timeout   = 1'b0;
  assign o_bus_err = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cfg_unused
  end
`endif

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    rdata_d      = rdata_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    misaligned_d = 1'b0;
    stall        = 1'b0;
    case (state_q)
      IDLE: begin
        if (access && misaligned) begin
          misaligned_d = 1'b1;
          rdata_d      = '0;
        end else if (access) begin
          stall    = 1'b1;
          req_d    = 1'b1;
          we_d     = i_mem_write_m;
          addr_d   = {i_addr_m[ADDR_W-1:2], 2'b00};
          wdata_d  = wdata_fmt;
          be_d     = be_fmt;
          funct3_d = i_funct3_m;
          offset_d = offset;
          state_d  = REQ;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (i_bus_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = fmt_load(i_bus_rdata, offset_q, funct3_q);
          state_d = DONE;
        end else if (timeout) begin
          req_d   = 1'b0;
          rdata_d = '0;
          state_d = DONE;
        end
      end
      // The pipeline advances at the end of DONE, so the instruction is never reissued.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (i_rst) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      rdata_q      <= '0;
      funct3_q     <= '0;
      offset_q     <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      rdata_q      <= rdata_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign o_bus_req    = req_q;
  assign o_bus_we     = we_q;
  assign o_bus_addr   = addr_q;
  assign o_bus_wdata  = wdata_q;
  assign o_bus_be     = be_q;
  assign o_rdata_m    = rdata_q;
  assign o_misaligned = misaligned_q;
  assign o_stall      = stall;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs (ALU result as address, forwarded rs2 as store data, write/read controls) and runs a req/ack transaction on the external data bus. While a transaction is outstanding it stalls the pipeline by dropping the EX/MEM and earlier clock enables. It formats store byte lanes and sign- or zero-extends load data for the MEM/WB register.

Parameters:
ADDR_W, 32, bus address width; the low 2 bits are always zero on the bus
TIMEOUT_CYCLES, 64, ack wait limit; used only with LSU_TIMEOUT_EN

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
i_addr_m  in  32  byte address (ALU result)
i_wdata_m  in  32  store data (forwarded rs2)
i_mem_write_m  in  1  store request
i_mem_read_m  in  1  load request (result_src == 2'b01)
i_funct3_m  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
o_bus_req  out  1  bus request, registered
o_bus_we  out  1  1 = write
o_bus_addr  out  ADDR_W  word-aligned address
o_bus_wdata  out  32  lane-replicated store data
o_bus_be  out  4  byte enables
i_bus_ack  in  1  transaction complete
i_bus_rdata  in  32  read word, valid with ack
o_stall  out  1  hold EX/MEM and upstream (clk_en = ~o_stall)
o_rdata_m  out  32  extended load result
o_misaligned  out  1  one-cycle misalignment flag
o_bus_err  out  1  timeout flag (feature only; tied 0 otherwise)

Behaviour:
- Reset values: o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be, o_rdata_m, o_misaligned and o_bus_err are all 0. FSM resets to IDLE.
- Access = i_mem_write_m | i_mem_read_m. If both are high, the write wins and no read is performed.
- FSM states: IDLE, REQ, DONE.
- IDLE, access present and aligned:
  - o_stall = 1 (combinational).
  - Register the bus fields, set o_bus_req, go to REQ.
- IDLE, access present and misaligned (H with addr[0]=1; W with addr[1:0]!=0):
  - No bus cycle, no stall.
  - o_misaligned pulses high for exactly the next cycle.
  - The store is suppressed; o_rdata_m is loaded with 0.
- REQ:
  - o_stall = 1; bus outputs are held stable.
  - On i_bus_ack: drop o_bus_req on the next edge. For a load, capture the formatted i_bus_rdata into o_rdata_m. Go to DONE.
- DONE: o_stall = 0 so the pipeline advances at the end of this cycle; next state is IDLE. The same instruction is never reissued.
- Minimum latency: access seen in cycle N, req in N+1, ack in N+1, DONE in N+2. That is 2 stall cycles.
- Store lanes, with offset = addr[1:0]:
  - SB: be = 1 << offset; wdata = {4{byte}}.
  - SH: be = 0011 for addr[1]=0, 1100 for addr[1]=1; wdata = {2{half}}.
  - SW: be = 1111.
  - funct3 011, 110 and 111 decode as a word access.
- Loads:
  - The byte or half is selected by offset, then sign-extended (B, H) or zero-extended (BU, HU).
  - o_bus_be = 1111 for all reads.
  - o_rdata_m holds its value until the next load completes.
- i_bus_ack outside REQ is ignored.
- Reset mid-transaction: o_bus_req is 0 after that edge, FSM returns to IDLE, and a late ack is ignored.

Optional Feature:
Macro: LSU_TIMEOUT_EN
- Defined:
  - A wait counter runs in REQ.
  - If TIMEOUT_CYCLES cycles pass without ack, drop o_bus_req, load 0 into o_rdata_m, pulse o_bus_err for one cycle, and go to DONE.
  - The counter clears on every REQ entry.
- Undefined: no counter; REQ waits indefinitely; o_bus_err is tied to 0.

Test Plan:
- SW addr 0x1004, wdata 0xDEADBEEF, ack 1 cycle after req -> bus_addr 0x1004, be 1111, we 1; o_stall high exactly 2 cycles.
- SB addr 0x2003, wdata 0x000000A5 -> be 1000, bus_wdata 0xA5A5A5A5, bus_addr 0x2000.
- LB addr 0x3001, rdata 0x0000_80_00 -> o_rdata_m 0xFFFFFF80. LHU addr 0x3002, rdata 0xBEEF0000 -> 0x0000BEEF.
- LW addr 0x4002 -> no req; o_misaligned high one cycle; o_stall stays 0; o_rdata_m = 0.
- Load with ack delayed 5 cycles, i_rst asserted in the 3rd wait cycle -> req 0 next cycle, FSM IDLE, later ack ignored, o_rdata_m = 0.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> req drops after 4 cycles, o_bus_err pulses, o_rdata_m = 0, stall releases in DONE.
